// File: rtl/feature_stream_loader_pkg.sv
// Shared types and constants for the feature stream loader: FSM encoding,
// feature-buffer read latency and the configuration legality check.
package feature_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_SWEEP,
    ST_LOAD,
    ST_DONE
  } state_t;

  // Feature buffer returns data this many cycles after the read strobe.
  localparam int RD_LAT = 1;

  // A row must hold at least one full window; the select index needs N >= 2.
  function automatic bit row_len_ok(input int row_len, input int n);
    return (row_len >= n) && (n >= 2);
  endfunction

endpackage

// File: rtl/feature_stream_loader.sv
// Row sequencer: clears and fills the feature shift register, then sweeps taps per window.
// Load strobe trails the read by RD_LAT cycles; stall_i only holds the sweep, never FILL or LOAD.
module feature_stream_loader
  import feature_stream_loader_pkg::*;
#(
  parameter int N          = 3,
  parameter int I_WIDTH    = 8,
  parameter int ROW_LEN    = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SEL_WIDTH  = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [I_WIDTH-1:0]    rd_data_i,
  output logic [I_WIDTH-1:0]    in_feature_o,
  output logic                  freg_ld_o,
  output logic                  freg_rst_o,
  output logic [SEL_WIDTH-1:0]  f_sel_o,
  output logic                  sel_valid_o
);

  localparam int FC_W    = $clog2(ROW_LEN + 1);
  localparam int WC_W    = $clog2(ROW_LEN - N + 2);
  localparam int WINDOWS = ROW_LEN - N + 1;

  if (!row_len_ok(ROW_LEN, N)) begin : g_cfg_check
    $error("feature_stream_loader: ROW_LEN (%0d) must be >= N (%0d) and N >= 2", ROW_LEN, N);
  end

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [FC_W-1:0]       feat_cnt_q;
  logic [WC_W-1:0]       win_cnt_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [RD_LAT-1:0]     ld_sr_q;
  logic                  rd_en;
  logic                  sel_last;
  logic                  last_win;
  logic                  fill_rd;
  logic                  sweep_go;

  assign sel_last = (sel_q == SEL_WIDTH'(N - 1));
  assign last_win = (win_cnt_q == WC_W'(WINDOWS - 1));
  assign fill_rd  = (feat_cnt_q < FC_W'(N));
  assign sweep_go = (state_q == ST_SWEEP) && !stall_i;

  always_comb begin
    state_nxt = state_q;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_i) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_FILL;
      ST_FILL: begin
        // N reads, then one extra cycle for the last load to land.
        if (fill_rd) rd_en = 1'b1;
        else         state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (sweep_go && sel_last) begin
          if (last_win) begin
            state_nxt = ST_DONE;
          end else begin
            rd_en     = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD:  state_nxt = ST_SWEEP;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      feat_cnt_q <= '0;
      win_cnt_q  <= '0;
      sel_q      <= '0;
      ld_sr_q    <= '0;
    end else begin
      state_q <= state_nxt;
      ld_sr_q <= RD_LAT'({ld_sr_q, rd_en});
      if (state_q == ST_IDLE && start_i) begin
        base_q     <= base_addr_i;
        feat_cnt_q <= '0;
        win_cnt_q  <= '0;
        sel_q      <= '0;
      end else begin
        if (rd_en) feat_cnt_q <= feat_cnt_q + 1'b1;
        if (sweep_go) begin
          if (sel_last) begin
            sel_q     <= '0;
            win_cnt_q <= win_cnt_q + 1'b1;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
      end
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign rd_en_o      = rd_en;
  assign rd_addr_o    = base_q + ADDR_WIDTH'(feat_cnt_q);
  assign in_feature_o = rd_data_i;
  assign freg_ld_o    = ld_sr_q[RD_LAT-1];
  assign freg_rst_o   = (state_q == ST_CLEAR);
  assign f_sel_o      = sel_q;
  assign sel_valid_o  = sweep_go;

endmodule
